// File: rtl/polar_dec_pkg.sv
// Shared sizing helpers, LLR limits and FSM states for the SC polar decoder LLR datapath.
package polar_dec_pkg;

  function automatic int llr_data_width(input int p, input int q);
    return (2 ** p) * q;
  endfunction

  function automatic int llr_depth(input int n, input int p);
    return (2 ** (n - p)) - 2 + p;
  endfunction

  function automatic int llr_addr_width(input int n, input int p);
    return $clog2(llr_depth(n, p));
  endfunction

  // Largest magnitude kept after saturation; the range is symmetric.
  function automatic int LLR_MAX(input int q);
    return (1 << (q - 1)) - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fg_state_t;

endpackage

// File: rtl/llr_fg_lane.sv
// Single-lane min-sum f / partial-sum g with symmetric saturation (purely combinational).
module llr_fg_lane import polar_dec_pkg::*; #(
  parameter int Q = 6
) (
  input  logic signed [Q-1:0] i_a,
  input  logic signed [Q-1:0] i_b,
  input  logic                i_u,
  input  logic                i_op_g,
  output logic signed [Q-1:0] o_res
);

  localparam logic signed [Q:0] MAXV = (Q+1)'(LLR_MAX(Q));
  localparam logic signed [Q:0] MINV = -MAXV;

  logic signed [Q:0] w_a_ext;
  logic signed [Q:0] w_b_ext;
  logic signed [Q:0] w_abs_a;
  logic signed [Q:0] w_abs_b;
  logic signed [Q:0] w_min;
  logic signed [Q:0] w_f;
  logic signed [Q:0] w_g;
  logic signed [Q:0] w_pre;
  logic signed [Q:0] w_sat;

  assign w_a_ext = {i_a[Q-1], i_a};
  assign w_b_ext = {i_b[Q-1], i_b};
  assign w_abs_a = i_a[Q-1] ? -w_a_ext : w_a_ext;
  assign w_abs_b = i_b[Q-1] ? -w_b_ext : w_b_ext;
  assign w_min   = (w_abs_a < w_abs_b) ? w_abs_a : w_abs_b;
  // A magnitude of 2^(Q-1) survives here and is clipped by the common saturation below.
  assign w_f     = (i_a[Q-1] ^ i_b[Q-1]) ? -w_min : w_min;
  assign w_g     = i_u ? (w_b_ext - w_a_ext) : (w_b_ext + w_a_ext);
  assign w_pre   = i_op_g ? w_g : w_f;
  assign w_sat   = (w_pre > MAXV) ? MAXV : ((w_pre < MINV) ? MINV : w_pre);
  assign o_res   = w_sat[Q-1:0];

endmodule

// File: rtl/llr_fg_engine.sv
// Streams len words from the LLR BRAM through 2^p f/g lanes and writes results back.
// state    | meaning
// IDLE     | waiting for start; len=0 finishes straight away via DRAIN
// ISSUE    | one read pair per cycle, word i = src + i
// DRAIN    | read issue finished, waiting for the done pulse of the last write
module llr_fg_engine import polar_dec_pkg::*; #(
  parameter  int n          = 5,
  parameter  int p          = 1,
  parameter  int Q          = 6,
  localparam int DATA_WIDTH = llr_data_width(p, Q),
  localparam int ADDR_WIDTH = llr_addr_width(n, p),
  localparam int LANES      = 2 ** p
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_g,
  input  logic [ADDR_WIDTH-1:0] src_a_addr,
  input  logic [ADDR_WIDTH-1:0] src_b_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] psum_idx,
  input  logic [LANES-1:0]      psum,
  output logic                  rea,
  output logic                  reb,
  output logic [ADDR_WIDTH-1:0] rd_addra,
  output logic [ADDR_WIDTH-1:0] rd_addrb,
  input  logic [DATA_WIDTH-1:0] douta,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   L_ONE = (ADDR_WIDTH+1)'(1);

  fg_state_t             r_state;
  logic                  r_op;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [ADDR_WIDTH-1:0] r_dst_ptr;
  logic                  r_done;

  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic                  r_s1_op;
  logic [LANES-1:0]      r_s1_psum;
  logic [ADDR_WIDTH-1:0] r_s1_waddr;

  logic [DATA_WIDTH-1:0] w_res;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= 1'b0;
      r_remain  <= '0;
      r_dst_ptr <= '0;
      r_done    <= 1'b0;
      rea       <= 1'b0;
      reb       <= 1'b0;
      rd_addra  <= '0;
      rd_addrb  <= '0;
      psum_idx  <= '0;
    end else begin
      r_done <= r_s1_valid && r_s1_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= op_g;
            r_remain  <= len;
            r_dst_ptr <= dst_addr;
            if (len == '0) begin
              r_state <= ST_DRAIN;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_ISSUE;
              rea      <= 1'b1;
              reb      <= 1'b1;
              rd_addra <= src_a_addr;
              rd_addrb <= src_b_addr;
              psum_idx <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_remain  <= r_remain - L_ONE;
          r_dst_ptr <= r_dst_ptr + A_ONE;
          if (r_remain == L_ONE) begin
            r_state  <= ST_DRAIN;
            rea      <= 1'b0;
            reb      <= 1'b0;
            rd_addra <= '0;
            rd_addrb <= '0;
            psum_idx <= '0;
          end else begin
            rd_addra <= rd_addra + A_ONE;
            rd_addrb <= rd_addrb + A_ONE;
            psum_idx <= psum_idx + A_ONE;
          end
        end
        ST_DRAIN: begin
          if (r_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1 tags the read issued this cycle; its data arrives as douta/doutb next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_op    <= 1'b0;
      r_s1_psum  <= '0;
      r_s1_waddr <= '0;
      we         <= 1'b0;
      wr_addr    <= '0;
      din        <= '0;
    end else begin
      r_s1_valid <= (r_state == ST_ISSUE);
      r_s1_last  <= (r_state == ST_ISSUE) && (r_remain == L_ONE);
      r_s1_op    <= r_op;
      r_s1_psum  <= psum;
      r_s1_waddr <= r_dst_ptr;
      we         <= r_s1_valid;
      wr_addr    <= r_s1_valid ? r_s1_waddr : '0;
      din        <= r_s1_valid ? w_res : '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    llr_fg_lane #(.Q(Q)) u_lane (
      .i_a    (douta[k*Q +: Q]),
      .i_b    (doutb[k*Q +: Q]),
      .i_u    (r_s1_psum[k]),
      .i_op_g (r_s1_op),
      .o_res  (w_res[k*Q +: Q])
    );
  end

endmodule

// File: tb/tb_llr_fg_engine.sv
// Scoreboard bench for llr_fg_engine: BRAM model, integer f/g reference, read/write/done queues.
module tb_llr_fg_engine;

  localparam int Q  = 6;
  localparam int L  = 2;
  localparam int AW = 4;
  localparam int DW = 12;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] idx;
    int            cyc;
  } rd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
    logic          last;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start, op_g;
  logic [AW-1:0] src_a_addr, src_b_addr, dst_addr;
  logic [AW:0]   len;
  logic [AW-1:0] psum_idx;
  logic [L-1:0]  psum;
  logic          rea, reb, we, busy, done;
  logic [AW-1:0] rd_addra, rd_addrb, wr_addr;
  logic [DW-1:0] douta, doutb, din;

  logic [DW-1:0] mem [16];
  logic [L-1:0]  psum_tab [16];
  logic          tb_wr;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_wr = 0;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  rd_t m_rd;
  wr_t m_wr;
  int  m_done;

  llr_fg_engine dut (
    .clk(clk), .rst(rst), .start(start), .op_g(op_g),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .dst_addr(dst_addr), .len(len),
    .psum_idx(psum_idx), .psum(psum),
    .rea(rea), .reb(reb), .rd_addra(rd_addra), .rd_addrb(rd_addrb),
    .douta(douta), .doutb(doutb),
    .we(we), .wr_addr(wr_addr), .din(din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign psum = psum_tab[psum_idx];

  // Two read ports with one cycle latency, one write port shared with bench preload.
  always @(posedge clk) begin
    if (rea) douta <= mem[rd_addra];
    if (reb) doutb <= mem[rd_addrb];
    if (we) mem[wr_addr] <= din;
    else if (tb_wr) mem[tb_wa] <= tb_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [L-1:0] u, input logic g);
    logic [DW-1:0] res;
    int av, bv, ma, mb, r;
    res = '0;
    for (int k = 0; k < L; k++) begin
      av = $signed(a[k*Q +: Q]);
      bv = $signed(b[k*Q +: Q]);
      if (g) begin
        r = u[k] ? bv - av : bv + av;
      end else begin
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        r  = (ma < mb) ? ma : mb;
        if ((av < 0) != (bv < 0)) r = -r;
      end
      if (r > 31) r = 31;
      if (r < -31) r = -31;
      res[k*Q +: Q] = Q'(r);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rea) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexp_read: rea=1 at cycle %0d, required no read", cyc);
        end else begin
          m_rd = rd_q.pop_front();
          chk("rd_addra", 32'(rd_addra), 32'(m_rd.a));
          chk("rd_addrb", 32'(rd_addrb), 32'(m_rd.b));
          chk("psum_idx", 32'(psum_idx), 32'(m_rd.idx));
          chk("rd_cycle", cyc, m_rd.cyc);
          chk("reb_with_rea", 32'(reb), 32'd1);
        end
      end else begin
        chk("idle_rd_outs", {reb, rd_addra, rd_addrb, psum_idx}, 32'd0);
      end
      if (we) begin
        n_wr++;
        if (wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexp_write: we=1 at cycle %0d addr %0d, required no write", cyc, wr_addr);
        end else begin
          m_wr = wr_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(m_wr.addr));
          chk("din", 32'(din), 32'(m_wr.data));
          chk("wr_cycle", cyc, m_wr.cyc);
          chk("done_with_we", 32'(done), 32'(m_wr.last));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexp_done: done=1 at cycle %0d, required none", cyc);
        end else begin
          m_done = done_q.pop_front();
          chk("done_cycle", cyc, m_done);
          chk("busy_with_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic mem_wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_wr = 1'b1; tb_wa = AW'(a); tb_wd = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    if ($urandom_range(0, 3) == 0) w[Q-1:0] = 6'b100000;
    if ($urandom_range(0, 3) == 0) w[2*Q-1:Q] = 6'b100000;
    return w;
  endfunction

  task automatic issue(input logic g, input int sa, input int sb, input int da, input int ln);
    int t;
    @(negedge clk);
    t = cyc;
    start = 1'b1; op_g = g; len = (AW+1)'(ln);
    src_a_addr = AW'(sa); src_b_addr = AW'(sb); dst_addr = AW'(da);
    for (int i = 0; i < ln; i++) begin
      rd_q.push_back('{a: AW'(sa + i), b: AW'(sb + i), idx: AW'(i), cyc: t + 1 + i});
      wr_q.push_back('{addr: AW'(da + i),
                       data: ref_word(mem[(sa + i) % 16], mem[(sb + i) % 16], psum_tab[i], g),
                       cyc: t + 3 + i, last: (i == ln - 1)});
    end
    done_q.push_back((ln == 0) ? t + 1 : t + 2 + ln);
    @(negedge clk);
    start = 1'b0;
    op_g = 1'($urandom); len = (AW+1)'($urandom_range(0, 15));
    src_a_addr = AW'($urandom); src_b_addr = AW'($urandom); dst_addr = AW'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no done within 60 cycles, required done");
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rea"}, 32'(rea), 32'd0);
    chk({nm, "_reb"}, 32'(reb), 32'd0);
    chk({nm, "_we"}, 32'(we), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_rd_addra"}, 32'(rd_addra), 32'd0);
    chk({nm, "_rd_addrb"}, 32'(rd_addrb), 32'd0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_psum_idx"}, 32'(psum_idx), 32'd0);
    chk({nm, "_din"}, 32'(din), 32'd0);
  endtask

  initial begin
    int w0, ln, mode, sa, sb, da;
    start = 1'b0; op_g = 1'b0; len = '0;
    src_a_addr = '0; src_b_addr = '0; dst_addr = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 16; i++) psum_tab[i] = '0;
    repeat (3) @(negedge clk);
    check_zero("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");

    // f: a=(5,-31) b=(-3,-31) -> (-3,31)
    mem_wr(0, 12'h845);
    mem_wr(1, 12'h87D);
    issue(1'b0, 0, 1, 2, 1);
    wait_done();
    @(negedge clk);
    chk("f_directed_mem", 32'(mem[2]), 32'h7FD);

    // g: a=(20,-32) b=(20,0) psum=10 -> (31,31)
    mem_wr(3, 12'h814);
    mem_wr(4, 12'h014);
    psum_tab[0] = 2'b10;
    issue(1'b1, 3, 4, 5, 1);
    wait_done();
    @(negedge clk);
    chk("g_directed_mem", 32'(mem[5]), 32'h7DF);

    for (int i = 0; i < 16; i++) mem_wr(i, rand_word());
    for (int i = 0; i < 16; i++) psum_tab[i] = L'($urandom);
    issue(1'($urandom), 0, 4, 8, 4);
    wait_done();

    issue(1'b0, 3, 7, 11, 0);
    wait_done();

    w0 = n_wr;
    issue(1'b1, 0, 5, 10, 3);
    @(negedge clk);
    start = 1'b1; len = (AW+1)'(2); src_a_addr = AW'(12); dst_addr = AW'(1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    chk("ignored_start_writes", n_wr - w0, 32'd3);

    issue(1'b0, 0, 4, 8, 4);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("mid_rst");
    rd_q.delete(); wr_q.delete(); done_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = n_wr;
    repeat (8) @(negedge clk);
    chk("no_wr_after_rst", n_wr - w0, 32'd0);
    issue(1'b1, 1, 6, 11, 4);
    wait_done();

    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 15; i++) mem_wr(i, rand_word());
      for (int i = 0; i < 16; i++) psum_tab[i] = L'($urandom);
      ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      sa = (ln == 0) ? 0 : $urandom_range(0, 5 - ln);
      sb = 5 + ((ln == 0) ? 0 : $urandom_range(0, 5 - ln));
      da = (mode == 0) ? 10 + ((ln == 0) ? 0 : $urandom_range(0, 5 - ln)) : ((mode == 1) ? sa : sb);
      issue(1'($urandom), sa, sb, da, ln);
      wait_done();
    end

    repeat (6) @(negedge clk);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/llr_fg_engine.md
# llr_fg_engine

Pipelined f/g processing engine for the SC polar decoder LLR datapath. Sits directly in front of the LLR multiport BRAM: it drives both read ports, consumes `douta`/`doutb`, computes 2^p parallel min-sum f or g results, and writes them back through the BRAM write port. One command processes `len` consecutive memory words at one word per cycle.

## Interface
- `n`, default 5: log2 code length.
- `p`, default 1: log2 lanes per word.
- `Q`, default 6: LLR width, two's complement.
- Derived: DATA_WIDTH = (2^p)*Q; DEPTH = 2^(n-p)-2+p; ADDR_WIDTH = clog2(DEPTH).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: command strobe; sampled only when `busy`=0.
- `op_g` in 1: 0 = f, 1 = g; latched at start.
- `src_a_addr` in ADDR_WIDTH: first word of operand a.
- `src_b_addr` in ADDR_WIDTH: first word of operand b.
- `dst_addr` in ADDR_WIDTH: first result word.
- `len` in ADDR_WIDTH+1: word count, 0..DEPTH.
- `psum_idx` out ADDR_WIDTH: word index whose partial sums are required this cycle.
- `psum` in 2^p: partial-sum bits for word `psum_idx`; bit k feeds lane k.
- `rea`, `reb` out 1: BRAM read enables.
- `rd_addra`, `rd_addrb` out ADDR_WIDTH: BRAM read addresses.
- `douta`, `doutb` in DATA_WIDTH: BRAM read data, valid one cycle after `rea`/`reb`.
- `we` out 1; `wr_addr` out ADDR_WIDTH; `din` out DATA_WIDTH: BRAM write port.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
  - IDLE: `start`=1 latches the command. `len`>0 goes to ISSUE. `len`=0 pulses `done` next cycle, with no reads or writes.
  - ISSUE: asserts `rea`=`reb`=1 with addresses src+i for i=0..len-1, one per cycle. `psum_idx`=i; `psum` and `op_g` are captured into the pipeline that cycle. Goes to DRAIN after word len-1.
  - DRAIN: waits for the last write, then returns to IDLE.
- Lane k operates on bits [k*Q +: Q] of a = `douta` and b = `doutb`.
  - f: sign(a) XOR sign(b) applied to min(|a|,|b|).
  - g: b + a if psum[k]=0, b - a if psum[k]=1.
  - Arithmetic is Q+1 bits, then saturated to the symmetric range [-(2^(Q-1)-1), +(2^(Q-1)-1)]. |−2^(Q-1)| is treated as 2^(Q-1)-1.
- Address counters wrap modulo 2^ADDR_WIDTH. Caller keeps ranges inside DEPTH.
- Destination may equal `src_a_addr` or `src_b_addr` (in-place is safe). Any other overlap of the dst and src ranges is illegal. There is no forwarding.
- `start` while `busy`=1 is ignored.
- `rst` at any time: FSM to IDLE, pipeline valids cleared, no further writes.

## Timing
- Reset values: `rea`=`reb`=`we`=`busy`=`done`=0; all address outputs, `psum_idx` and `din` = 0.
- `rea`/`reb` and all address outputs are 0 whenever no read is issued.
- Start accepted at cycle T: word i is read at T+1+i, data returns at T+2+i, and `we` for word i with `wr_addr`=dst+i is registered at T+3+i.
- `done` is asserted in the same cycle as the last `we` (T+2+len). `busy` is 1 from T+1 through the `done` cycle inclusive.
- For `len`=0: `busy`=1 and `done`=1 together at T+1 only.
- Throughput is one word per cycle. The earliest next start is the cycle after `done`.

## Structure
- Shared package `polar_dec_pkg`:
  - functions `llr_data_width(p,Q)`, `llr_depth(n,p)`, `llr_addr_width(n,p)`;
  - constant pattern `LLR_MAX(Q)`;
  - FSM state enum.
- Sub-module `llr_fg_lane`: combinational single-lane f/g with saturation (a, b, u, op_g -> Q-bit result), generated 2^p times.
- Top-level module: FSM, counters, two-stage valid/address/op pipeline and the output register.

## Test plan
- Q=6, f, one word, lanes a=(5,-31), b=(-3,-31) -> din lanes (-3, 31); `we` at T+3, `done` at T+3.
- g, a=(20,-32), b=(20,0), psum=2'b10 -> lane0 31 (saturated 40), lane1 31 (0-(-32) saturated).
- `len`=4, src_a=0, src_b=4, dst=8 -> reads at T+1..T+4, `wr_addr` 8..11 at T+3..T+6, `psum_idx` 0..3 at T+1..T+4, `done` at T+6.
- `len`=0 -> `done` at T+1, no `rea` and no `we` ever asserted.
- `start` pulsed at T+2 during a `len`=3 command -> ignored; exactly 3 writes occur.
- `rst` asserted at T+3 of a `len`=4 command -> all outputs 0 immediately; no `we` after reset; a new command then completes normally.
